// File: rtl/dma_fsm_mc.sv
// DMA sequencer. It walks the eligible descriptors, lowest index first, and drives
// independent read and write streamer requests, with error capture, abort and a progress watchdog.
module dma_fsm_mc #(
    parameter int N_DESC      = 8,
    parameter int SIZE_W      = 32,
    parameter int ADDR_W      = 32,
    parameter int TMO_W       = 16,
    parameter int HALT_ON_ERR = 1,
    localparam int IDX_W      = $clog2(N_DESC)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     go_i,
    input  logic                     abort_i,
    input  logic [TMO_W-1:0]         tmo_limit_i,
    input  logic [N_DESC-1:0]        desc_valid_i,
    input  logic [N_DESC*SIZE_W-1:0] desc_size_i,
    input  logic                     axi_pend_txn_i,
    input  logic                     axi_err_i,
    input  logic                     axi_err_wr_i,
    input  logic [ADDR_W-1:0]        axi_err_addr_i,
    output logic                     rd_req_o,
    output logic [IDX_W-1:0]         rd_idx_o,
    input  logic                     rd_done_i,
    output logic                     wr_req_o,
    output logic [IDX_W-1:0]         wr_idx_o,
    input  logic                     wr_done_i,
    output logic                     dma_active_o,
    output logic                     dma_done_o,
    output logic                     dma_err_o,
    output logic                     err_wr_o,
    output logic [ADDR_W-1:0]        err_addr_o,
    output logic                     tmo_o,
    output logic                     clear_dma_o
);

    typedef enum logic [1:0] {S_IDLE, S_CFG, S_RUN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic [N_DESC-1:0]  elig, rd_mask, wr_mask;
    logic               abort_ff;
    logic [TMO_W-1:0]   tmo_cnt;
    logic               rd_found, wr_found, run, rd_acc, wr_acc, wdog_fire;
    logic [IDX_W-1:0]   rd_sel, wr_sel;

    always_comb begin
        elig = '0;
        for (int i = 0; i < N_DESC; i++)
            elig[i] = desc_valid_i[i] && (desc_size_i[i*SIZE_W +: SIZE_W] != '0);
    end

    // Scanning downward makes the last hit the lowest pending index.
    always_comb begin
        rd_found = 1'b0;
        rd_sel   = '0;
        wr_found = 1'b0;
        wr_sel   = '0;
        for (int i = N_DESC - 1; i >= 0; i--) begin
            if (elig[i] && !rd_mask[i]) begin
                rd_found = 1'b1;
                rd_sel   = IDX_W'(i);
            end
            if (elig[i] && !wr_mask[i]) begin
                wr_found = 1'b1;
                wr_sel   = IDX_W'(i);
            end
        end
    end

    assign run          = (state_q == S_RUN);
    assign rd_req_o     = run && !abort_ff && rd_found && !rst;
    assign wr_req_o     = run && !abort_ff && wr_found && !rst;
    assign rd_idx_o     = rd_req_o ? rd_sel : '0;
    assign wr_idx_o     = wr_req_o ? wr_sel : '0;
    assign rd_acc       = rd_req_o && rd_done_i;
    assign wr_acc       = wr_req_o && wr_done_i;
    assign wdog_fire    = run && !rd_acc && !wr_acc && (tmo_limit_i != '0) &&
                          (tmo_cnt == tmo_limit_i - TMO_W'(1));
    assign dma_active_o = run;
    assign dma_done_o   = (state_q == S_DONE);
    assign clear_dma_o  = (state_q == S_DONE) && (state_d == S_IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (go_i) state_d = S_CFG;
            S_CFG:  state_d = (!abort_i && (|elig)) ? S_RUN : S_DONE;
            S_RUN:  if (wdog_fire || (!rd_req_o && !wr_req_o && !axi_pend_txn_i))
                        state_d = S_DONE;
            S_DONE: if (!go_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rd_mask    <= '0;
            wr_mask    <= '0;
            abort_ff   <= 1'b0;
            tmo_cnt    <= '0;
            dma_err_o  <= 1'b0;
            err_wr_o   <= 1'b0;
            err_addr_o <= '0;
            tmo_o      <= 1'b0;
        end else begin
            state_q <= state_d;

            if (state_q == S_DONE) begin
                rd_mask <= '0;
                wr_mask <= '0;
            end else begin
                if (rd_acc) rd_mask[rd_idx_o] <= 1'b1;
                if (wr_acc) wr_mask[wr_idx_o] <= 1'b1;
            end

            // Watchdog counts only stalled RUN cycles and saturates instead of wrapping.
            if (!run || rd_acc || wr_acc)
                tmo_cnt <= '0;
            else if (tmo_cnt != '1)
                tmo_cnt <= tmo_cnt + TMO_W'(1);

            if (state_q == S_CFG) begin
                dma_err_o  <= 1'b0;
                err_wr_o   <= 1'b0;
                err_addr_o <= '0;
                tmo_o      <= 1'b0;
                abort_ff   <= 1'b0;
            end else begin
                if (run && abort_i)
                    abort_ff <= 1'b1;
                if (axi_err_i && (HALT_ON_ERR != 0))
                    abort_ff <= 1'b1;
                if (wdog_fire) begin
                    tmo_o    <= 1'b1;
                    abort_ff <= 1'b1;
                end
                if (axi_err_i && !dma_err_o) begin
                    dma_err_o  <= 1'b1;
                    err_wr_o   <= axi_err_wr_i;
                    err_addr_o <= axi_err_addr_i;
                end
            end
        end
    end

endmodule

// File: doc/dma_fsm_mc.md
Name: dma_fsm_mc

Overview:
- Parametrised next-generation DMA sequencer: N_DESC descriptors, configurable size/address widths.
- Walks valid, non-zero-size descriptors, issuing read and write streamer requests independently, lowest index first.
- Adds sticky first-error capture, optional halt-on-error, and a programmable progress watchdog.
- Sits between the CSR/descriptor bank and the AXI read/write streamers.

Parameters:
N_DESC, 8, number of descriptors (>=2)
SIZE_W, 32, descriptor size field width
ADDR_W, 32, error address width
TMO_W, 16, watchdog counter width
HALT_ON_ERR, 1, 1 = AXI error aborts the run; 0 = error only logged
IDX_W (localparam), $clog2(N_DESC), descriptor index width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
go_i  in  1  start; held high to remain in DONE
abort_i  in  1  abort request
tmo_limit_i  in  TMO_W  watchdog limit; 0 disables
desc_valid_i  in  N_DESC  per-descriptor enable
desc_size_i  in  N_DESC*SIZE_W  packed sizes, descriptor i at [i*SIZE_W +: SIZE_W]
axi_pend_txn_i  in  1  AXI transactions outstanding
axi_err_i  in  1  AXI error strobe
axi_err_wr_i  in  1  error is on the write path
axi_err_addr_i  in  ADDR_W  faulting address
rd_req_o  out  1  read streamer request valid
rd_idx_o  out  IDX_W  read descriptor index
rd_done_i  in  1  read streamer finished current descriptor
wr_req_o  out  1  write streamer request valid
wr_idx_o  out  IDX_W  write descriptor index
wr_done_i  in  1  write streamer finished current descriptor
dma_active_o  out  1  state==RUN
dma_done_o  out  1  state==DONE
dma_err_o  out  1  sticky error flag
err_wr_o  out  1  captured error direction
err_addr_o  out  ADDR_W  captured error address
tmo_o  out  1  sticky watchdog expiry flag
clear_dma_o  out  1  one-cycle pulse on DONE->IDLE

Behaviour:
- Reset:
  - State IDLE.
  - All outputs 0.
  - rd/wr done masks, watchdog counter and abort_ff cleared.
  - Reset mid-run drops requests in the same cycle the reset is sampled.
- Eligible(i) = desc_valid_i[i] && desc_size_i[i] != 0.
- States IDLE, CFG, RUN, DONE:
  - IDLE: go_i -> CFG.
  - CFG (exactly 1 cycle):
    - Clears dma_err_o, err_wr_o, err_addr_o, tmo_o, abort_ff.
    - Goes to RUN if !abort_i and any Eligible; else DONE.
  - RUN: goes to DONE when any of the following holds:
    - (!rd_req_o && !wr_req_o && !axi_pend_txn_i), evaluated combinationally in the same cycle.
    - Watchdog expiry, which exits immediately regardless of pending.
  - DONE: stays while go_i; go_i=0 -> IDLE with clear_dma_o=1 that cycle only (combinational: cur==DONE && next==IDLE).
- Request generation, combinational, RUN only:
  - rd_req_o=1 and rd_idx_o = lowest i with Eligible(i) && !rd_mask[i].
  - Otherwise rd_req_o=0 and rd_idx_o=0.
  - wr path is identical, using wr_mask.
- Done handling:
  - rd_done_i while rd_req_o=1 sets rd_mask[rd_idx_o] next cycle.
  - rd_done_i while rd_req_o=0 is ignored.
  - wr path is identical.
  - Masks clear while state==DONE.
- Abort:
  - abort_ff <= abort_i (registered) while in RUN.
  - It is also set by an AXI error when HALT_ON_ERR=1.
  - abort_ff sticks until CFG.
  - While abort_ff=1, rd_req_o and wr_req_o are forced 0. The done strobe in the same cycle still updates the masks.
  - RUN then exits when axi_pend_txn_i=0.
- Error capture:
  - The first axi_err_i in any state after CFG sets dma_err_o and latches err_wr_o and err_addr_o.
  - Later errors are ignored until the next CFG.
  - An error in IDLE is captured too; a following CFG clears it.
- Watchdog:
  - Counter increments each RUN cycle with no rd_done_i/wr_done_i accepted.
  - It resets to 0 on any accepted done, and outside RUN.
  - When tmo_limit_i!=0 and the counter == tmo_limit_i-1 while incrementing: tmo_o<=1, abort_ff<=1, next state DONE.
  - Counter saturates; no wrap.
- Simultaneous rd and wr done in one cycle: both masks update; counter resets.

Test Plan:
- Descriptors 0,2,5 valid (size 0x40); pulse go_i; ack rd/wr each cycle -> rd_idx_o sequence 0,2,5; DONE 1 cycle after last ack with axi_pend_txn_i=0; dma_done_o=1.
- Only desc 3 valid, size 0 -> CFG->DONE in 2 cycles; no rd_req_o/wr_req_o ever asserted; drop go_i -> clear_dma_o pulses once.
- HALT_ON_ERR=1, mid-run axi_err_i with addr 0xDEAD_0000 and wr=1, then a second error at 0x1234 -> err_addr_o=0xDEAD_0000, err_wr_o=1, requests 0 next cycle, DONE once axi_pend_txn_i falls.
- tmo_limit_i=10, streamers never ack -> tmo_o=1 and state DONE exactly 10 cycles after entering RUN.
- abort_i pulsed during RUN with axi_pend_txn_i high 4 cycles -> requests drop next cycle; DONE entered the cycle axi_pend_txn_i is 0.
- Assert rst in RUN with masks partly set -> all outputs 0 next cycle; a new go_i restarts from index 0.
